// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Bundles every read-side signal between an ASYNC_FIFO read port, the
// fifo_rd_stream drain stage and the downstream stream consumer.
//
//   fifo_empty  FIFO empty flag (read domain)
//   read_en     FIFO read strobe
//   read_data   FIFO data, valid the cycle after an accepted read_en
//   m_valid     stream word available
//   m_ready     consumer accepts the word
//   m_data      stream word
//   buf_level   skid-buffer occupancy, 0..3
//
// Modports:
//   master : the drain stage (drives read_en and the stream outputs)
//   slave  : the environment (FIFO read port plus stream consumer)
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
  parameter int RAM_WIDTH = 8
);
  logic                 fifo_empty;
  logic                 read_en;
  logic [RAM_WIDTH-1:0] read_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [RAM_WIDTH-1:0] m_data;
  logic [1:0]           buf_level;

  modport master (
    input  fifo_empty,
    input  read_data,
    input  m_ready,
    output read_en,
    output m_valid,
    output m_data,
    output buf_level
  );

  modport slave (
    output fifo_empty,
    output read_data,
    output m_ready,
    input  read_en,
    input  m_valid,
    input  m_data,
    input  buf_level
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain stage for ASYNC_FIFO. Turns the FIFO's read_en / read_data /
// fifo_empty port (one-cycle read latency) into a valid/ready stream running
// at one word per cycle. A 3-entry prefetch/skid buffer absorbs the words
// already requested when the consumer stalls, so read_en is computed only
// from registered state and fifo_empty, never from m_ready.
//
// Ports:
//   read_clk  in   read-domain clock (shared with the FIFO read port)
//   rst_n     in   asynchronous active-low reset, released synchronously
//   bus       if   fifo_rd_stream_if.master (FIFO side + stream side)
//
// Optional feature (macro FIFO_RD_STREAM_CNT_EN):
//   cnt_clr   in   synchronous clear of word_cnt, wins over increment
//   word_cnt  out  16-bit wrapping count of stream handshakes
// With the macro undefined neither port nor the counter exists.
//
// Parameters:
//   RAM_WIDTH   data width, must match the ASYNC_FIFO instance
//   SKID_DEPTH  buffer entries; only 3 is supported (the pointer wrap and the
//               issue threshold are built for exactly three entries)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int RAM_WIDTH  = 8,
  parameter int SKID_DEPTH = 3
) (
  input  logic                  read_clk,
  input  logic                  rst_n,
  fifo_rd_stream_if.master      bus
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [15:0]           word_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]           count_reg, count_next;   // words held in the buffer
  logic                 pend_reg;                // read issued last cycle
  logic [1:0]           head_reg, head_next;     // oldest word
  logic [1:0]           tail_reg, tail_next;     // next free slot
  logic                 run_reg;                 // 0 until the first edge after reset release
  logic [RAM_WIDTH-1:0] entry_reg [SKID_DEPTH];

  logic [2:0]           occ;                     // count + words in flight
  logic                 read_en_int;
  logic                 pop;
  logic                 m_valid_int;
  logic [RAM_WIDTH-1:0] head_data;

  // Three-entry ring: pointers step 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Issue rule. A read is only issued if the buffer can take it even when the
  // consumer stalls for good: the word in flight plus those held must fit.
  // run_reg keeps read_en low for the whole reset interval and releases it
  // on a clock edge, so the strobe never glitches on the async rst_n edge.
  // ---------------------------------------------------------------------------
  assign occ         = {1'b0, count_reg} + {2'b00, pend_reg};
  assign read_en_int = run_reg && !bus.fifo_empty && (occ < 3'd3);

  assign m_valid_int = (count_reg != 2'd0);
  assign pop         = m_valid_int && bus.m_ready;

  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    // Capture and pop in the same cycle leave count unchanged.
    count_next = count_reg + {1'b0, pend_reg} - {1'b0, pop};
    if (pend_reg) begin
      tail_next = ptr_inc(tail_reg);
    end
    if (pop) begin
      head_next = ptr_inc(head_reg);
    end
  end

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 2'd0;
      pend_reg  <= 1'b0;
      head_reg  <= 2'd0;
      tail_reg  <= 2'd0;
      run_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      pend_reg  <= read_en_int;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      run_reg   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage. Entries reset to zero so m_data reads 0 during reset
  // (head points at entry 0).
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg[gi] <= '0;
      end else if (pend_reg && (tail_reg == 2'(gi))) begin
        entry_reg[gi] <= bus.read_data;
      end
    end
  end

  // Head word select; the unused pointer code 3 never occurs.
  always_comb begin
    head_data = entry_reg[0];
    case (head_reg)
      2'd1:    head_data = entry_reg[1];
      2'd2:    head_data = entry_reg[2];
      default: head_data = entry_reg[0];
    endcase
  end

  assign bus.read_en   = read_en_int;
  assign bus.m_valid   = m_valid_int;
  assign bus.m_data    = head_data;
  assign bus.buf_level = count_reg;

`ifdef FIFO_RD_STREAM_CNT_EN
  // ---------------------------------------------------------------------------
  // Handshake counter, wraps naturally at 16 bits.
  // ---------------------------------------------------------------------------
  logic [15:0] word_cnt_reg;

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_reg <= 16'd0;
    end else if (cnt_clr) begin
      word_cnt_reg <= 16'd0;
    end else if (pop) begin
      word_cnt_reg <= word_cnt_reg + 16'd1;
    end
  end

  assign word_cnt = word_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Self-checking bench for fifo_rd_stream. A queue models the ASYNC_FIFO
// contents (one-cycle read latency); every word pushed into it is also pushed
// to a scoreboard queue and popped/compared on each stream handshake.
// Inputs change on the falling edge, outputs are sampled 2 ns later, well
// before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;
  localparam int W = 8;

  logic read_clk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 read_clk = ~read_clk;

  fifo_rd_stream_if #(.RAM_WIDTH(W)) bus ();

`ifdef FIFO_RD_STREAM_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] word_cnt;
`endif

  fifo_rd_stream #(.RAM_WIDTH(W), .SKID_DEPTH(3)) dut (
    .read_clk (read_clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .word_cnt (word_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] fifo_q [$];
  logic [W-1:0] exp_q  [$];
  logic [W-1:0] seq;
  logic [W-1:0] stash;
  bit           stash_valid = 0;
  bit           quiet = 0;

  // per-step samples and running statistics
  bit s_re, s_mv, s_hs;
  int s_lvl;
  int cyc = 0, rd_pulses = 0, hs = 0;
  int first_hs = -1, last_hs = -1;
  logic [W-1:0] last_hs_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle of FIFO model, consumer and scoreboard.
  task automatic step(input bit rdy, input int n_push);
    bit pend_m;
    @(negedge read_clk);
    for (int i = 0; i < n_push; i++) begin
      fifo_q.push_back(seq);
      exp_q.push_back(seq);
      seq = seq + 1'b1;
    end
    bus.m_ready = rdy;
    pend_m = stash_valid;
    if (stash_valid) bus.read_data = stash;
    stash_valid = 0;
    bus.fifo_empty = (fifo_q.size() == 0);
    #2;
    cyc++;
    s_re  = bus.read_en;
    s_mv  = bus.m_valid;
    s_lvl = int'(bus.buf_level);
    s_hs  = bus.m_valid && bus.m_ready;
    check("occupancy_le3", 32'(((s_lvl + int'(pend_m)) <= 3)), 32'd1);
    if (bus.fifo_empty) check("rd_while_empty", 32'(bus.read_en), 32'd0);
    if (bus.read_en && fifo_q.size() != 0) begin
      stash = fifo_q.pop_front();
      stash_valid = 1;
      rd_pulses++;
    end
    if (bus.m_valid && !bus.m_ready && exp_q.size() != 0)
      check("hold_data", 32'(bus.m_data), 32'(exp_q[0]));
    if (s_hs) begin
      hs++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      last_hs_data = bus.m_data;
      if (!quiet) $display("xfer cyc=%0d data=0x%02h level=%0d", cyc, bus.m_data, s_lvl);
      if (exp_q.size() == 0) check("spurious_word", 32'd1, 32'd0);
      else check("stream_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || stash_valid || fifo_q.size() != 0 || s_lvl != 0) && n < 300) begin
      step(1, 0);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int first_re, last_re, first_mv, hs0, rp0, n;
    logic [W-1:0] nxt;
    bus.fifo_empty = 1'b1;
    bus.read_data  = '0;
    bus.m_ready    = 1'b0;

    // ---------------- reset state + preload ----------------
    seq = 8'h00;
    step(1, 10);
    check("rst_read_en", 32'(bus.read_en), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_buf_level", 32'(bus.buf_level), 32'd0);
    step(1, 0);
    check("rst_read_en_hold", 32'(s_re), 32'd0);
    rst_n = 1'b1;
    first_re = -1; last_re = -1; first_mv = -1; rp0 = rd_pulses;
    for (int c = 0; c < 20; c++) begin
      step(1, 0);
      if (s_re) begin
        if (first_re < 0) first_re = c;
        last_re = c;
      end
      if (s_mv && first_mv < 0) first_mv = c;
    end
    check("pre_rd_pulses", 32'(rd_pulses - rp0), 32'd10);
    check("pre_rd_consec", 32'(last_re - first_re + 1), 32'd10);
    check("pre_latency", 32'(first_mv - first_re), 32'd2);
    check("pre_final_level", 32'(s_lvl), 32'd0);
    check("pre_all_out", 32'(exp_q.size()), 32'd0);

    // ---------------- backpressure ----------------
    seq = 8'h00; rp0 = rd_pulses;
    step(0, 20);
    for (int c = 0; c < 9; c++) step(0, 0);
    check("bp_rd_pulses", 32'(rd_pulses - rp0), 32'd3);
    check("bp_level", 32'(s_lvl), 32'd3);
    check("bp_m_data", 32'(bus.m_data), 32'h00);
    first_hs = -1; hs0 = hs;
    for (int c = 0; c < 30; c++) step(1, 0);
    check("bp_count", 32'(hs - hs0), 32'd20);
    check("bp_no_gaps", 32'(last_hs - first_hs + 1), 32'd20);
    check("bp_last", 32'(last_hs_data), 32'h13);
    drain();

    // ---------------- ready toggle, 1 word/cycle feed ----------------
    for (int c = 0; c < 40; c++) step(bit'(c[0]), 1);
    drain();

    // ---------------- FIFO runs dry ----------------
    hs0 = hs;
    step(1, 2);
    for (int c = 0; c < 8; c++) step(1, 0);
    check("dry_count", 32'(hs - hs0), 32'd2);
    check("dry_m_valid", 32'(s_mv), 32'd0);
    check("dry_read_en", 32'(s_re), 32'd0);

    // ---------------- mid-traffic reset ----------------
    step(0, 5);
    n = 0;
    while (s_lvl != 2 && n < 10) begin
      step(0, 0);
      n++;
    end
    check("mr_reach_lvl2", 32'(s_lvl), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mr_read_en", 32'(bus.read_en), 32'd0);
    check("mr_m_valid", 32'(bus.m_valid), 32'd0);
    check("mr_m_data", 32'(bus.m_data), 32'd0);
    check("mr_buf_level", 32'(bus.buf_level), 32'd0);
    // Buffered and in-flight words are lost; what stays in the FIFO remains.
    exp_q = fifo_q;
    stash_valid = 0;
    nxt = fifo_q[0];
    step(1, 0);
    step(1, 0);
    check("mr_rd_in_reset", 32'(s_re), 32'd0);
    rst_n = 1'b1;
    hs0 = hs;
    n = 0;
    while (hs == hs0 && n < 20) begin
      step(1, 0);
      n++;
    end
    check("mr_first_word", 32'(last_hs_data), 32'(nxt));
    drain();

`ifdef FIFO_RD_STREAM_CNT_EN
    // ---------------- handshake counter ----------------
    cnt_clr = 1'b1;
    step(1, 0);
    cnt_clr = 1'b0;
    step(1, 0);
    check("cnt_cleared", 32'(word_cnt), 32'd0);
    quiet = 1;
    hs0 = hs;
    for (int c = 0; c < 70000; c++) step(1, 1);
    drain();
    quiet = 0;
    check("cnt_hs_total", 32'(hs - hs0), 32'd70000);
    check("cnt_wrap", 32'(word_cnt), 32'(70000 % 65536));
    step(0, 3);
    n = 0;
    while (!(bus.m_valid) && n < 10) begin
      step(0, 0);
      n++;
    end
    step(1, 0);
    check("cnt_clr_hs", 32'(s_hs), 32'd1);
    cnt_clr = 1'b1;
    step(0, 0);
    cnt_clr = 1'b0;
    check("cnt_clr_prio", 32'(word_cnt), 32'd0);
    hs0 = hs;
    drain();
    check("cnt_after_clr", 32'(word_cnt), 32'(hs - hs0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of ASYNC_FIFO, entirely in the read clock domain.
- Converts the FIFO's read_en/read_data/fifo_empty interface (one-cycle read latency) into a valid/ready stream with full throughput.
- Holds words in a 3-entry prefetch/skid buffer, so read_en never depends combinationally on m_ready.
- Feeds the downstream consumer logic in the read domain.

Parameters:
- RAM_WIDTH, 8, data width; must match the ASYNC_FIFO instance.
- SKID_DEPTH, 3, prefetch buffer entries; fixed at 3 (minimum for full rate at 1-cycle FIFO latency); other values unsupported.

Ports:
- read_clk  input  1  read-domain clock, shared with the ASYNC_FIFO read port.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  ASYNC_FIFO empty flag, read domain.
- read_en  output  1  FIFO read strobe.
- read_data  input  RAM_WIDTH  FIFO data; valid the cycle after read_en is high while fifo_empty is low.
- m_valid  output  1  stream word available.
- m_ready  input  1  consumer accepts the word.
- m_data  output  RAM_WIDTH  stream word, head of the skid buffer.
- buf_level  output  2  current skid-buffer occupancy, 0..3.

Behaviour:
- Reset (asynchronous assert, synchronous release): read_en=0, m_valid=0, m_data=0, buf_level=0, pend=0, head/tail pointers=0.
- Reset mid-operation discards buffered and in-flight words, with no recovery.
- State:
  - count (0..3);
  - pend (1 bit, a read issued last cycle whose data arrives this cycle);
  - 3-entry register array with 2-bit head/tail pointers, wrapping 2 -> 0.
- Issue rule: read_en = !fifo_empty && (count + pend) < 3.
  - Purely from registered state and fifo_empty.
  - read_en is never high while fifo_empty=1.
- pend <= read_en each cycle.
- Capture: when pend=1, write read_data to entry[tail] and advance tail.
- Pop: when m_valid && m_ready, advance head.
- Count update: count_next = count + pend - pop. Capture and pop may occur in the same cycle; if so, count is unchanged.
- m_valid = (count != 0); m_data = entry[head], driven from registers.
- Latency: a word present in the FIFO with the buffer empty reaches m_valid 2 cycles after fifo_empty falls. Cycle 0 read_en, cycle 1 capture, cycle 2 m_valid.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and m_ready=1.
- Stream rule: m_data is held stable while m_valid=1 and m_ready=0. m_valid never drops without a handshake.
- Invariant: count + pend <= 3 always, so the buffer never overflows.
- buf_level = count.

Optional Feature:
- Macro: FIFO_RD_STREAM_CNT_EN.
- Defined:
  - adds output word_cnt [15:0], reset 0;
  - increments on every m_valid && m_ready;
  - wraps 0xFFFF -> 0x0000;
  - adds input cnt_clr (synchronous, clears to 0 with priority over increment).
- Undefined: neither port exists; no counter logic.

Test Plan:
- Pre-load: FIFO preloaded with 0x00..0x09, m_ready=1, release reset -> read_en high for 10 consecutive cycles; m_data 0x00..0x09 on consecutive cycles; m_valid first rises 2 cycles after read_en; final buf_level=0.
- Backpressure: 20 words queued, m_ready=0 -> read_en pulses exactly 3 times; buf_level=3; m_data=0x00 stable. Then m_ready=1 -> 0x00..0x13 delivered in order with no gaps or duplicates.
- Ready toggle: m_ready toggles every cycle, FIFO continuously fed at 1 word/cycle -> output sequence strictly incrementing; count+pend never exceeds 3 (assertion).
- FIFO runs dry: FIFO holds 2 words, m_ready=1 -> 2 words delivered, then m_valid=0. read_en stays 0 while fifo_empty=1.
- Mid-traffic reset: rst_n asserted while buf_level=2 -> all outputs 0 in the same cycle; after release, the next FIFO word is delivered first.
- Counter (FIFO_RD_STREAM_CNT_EN): 70000 handshakes -> word_cnt=70000 mod 65536=4464. cnt_clr during a handshake cycle -> word_cnt=0.
